mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 110 +++++++++++
 tb/tb_mem_port_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin N:1 memory request arbiter with a grant-ID FIFO
// that routes in-order responses back to the requesting channel.
module mem_port_arbiter #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         ch_req_valid,
    input  logic [NUM_CH*ADDR_W-1:0]  ch_req_addr,
    input  logic [NUM_CH*DATA_W-1:0]  ch_req_data,
    input  logic [NUM_CH*2-1:0]       ch_req_fcn,
    input  logic [NUM_CH*3-1:0]       ch_req_typ,
    output logic [NUM_CH-1:0]         ch_req_ready,
    output logic [NUM_CH-1:0]         ch_res_valid,
    output logic [DATA_W-1:0]         ch_res_data,
    output logic                      mem_req_valid,
    output logic [ADDR_W-1:0]         mem_req_addr,
    output logic [DATA_W-1:0]         mem_req_data,
    output logic [1:0]                mem_req_fcn,
    output logic [2:0]                mem_req_typ,
    input  logic                      mem_req_ready,
    input  logic                      mem_res_valid,
    input  logic [DATA_W-1:0]         mem_res_data,
    output logic [$clog2(DEPTH):0]    outstanding,
    output logic                      err_unexpected_res
);
    localparam int IW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int PW = $clog2(DEPTH);
    localparam logic [IW:0] NC = (IW+1)'(NUM_CH);
    localparam logic [IW:0] ONE_I = (IW+1)'(1);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0] ONE_C = (PW+1)'(1);

    logic [IW-1:0] rr_q, rr_d, hold_q, sel, off;
    logic [IW:0] sum, nxt;
    logic [2*NUM_CH-1:0] rot;
    logic lock_q, lock_d, err_q, full, empty, accept, pop;
    logic [PW:0] cnt_q, cnt_d;
    logic [PW-1:0] wr_q, rd_q;
    logic [IW-1:0] ids_q [DEPTH];

    // rotate valids so bit k is channel (rr+k) mod NUM_CH, then take the lowest set bit
    assign rot = {ch_req_valid, ch_req_valid} >> rr_q;
    always_comb begin
        off = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) off = rot[k] ? IW'(k) : off;
    end
    assign sum = {1'b0, rr_q} + {1'b0, off};
    assign sel = lock_q ? hold_q : (sum >= NC ? IW'(sum - NC) : sum[IW-1:0]);
    assign nxt = {1'b0, sel} + ONE_I;

    assign full = cnt_q == FULL;
    assign empty = cnt_q == '0;
    assign mem_req_valid = !reset && (|ch_req_valid || lock_q) && !full;
    assign accept = mem_req_valid && mem_req_ready;
    assign pop = !reset && mem_res_valid && !empty;
    assign outstanding = cnt_q;
    assign err_unexpected_res = err_q;
    assign ch_res_data = mem_res_data;

    always_comb begin
        mem_req_addr = '0;
        mem_req_data = '0;
        mem_req_fcn = '0;
        mem_req_typ = '0;
        ch_req_ready = '0;
        ch_res_valid = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == IW'(i)) begin
                mem_req_addr = ch_req_addr[i*ADDR_W +: ADDR_W];
                mem_req_data = ch_req_data[i*DATA_W +: DATA_W];
                mem_req_fcn = ch_req_fcn[i*2 +: 2];
                mem_req_typ = ch_req_typ[i*3 +: 3];
                ch_req_ready[i] = accept;
            end
            ch_res_valid[i] = pop && ids_q[rd_q] == IW'(i);
        end
    end

    assign rr_d = accept ? (nxt == NC ? '0 : nxt[IW-1:0]) : rr_q;
    assign lock_d = (mem_req_valid && !mem_req_ready) ? 1'b1 : (accept ? 1'b0 : lock_q);
    assign cnt_d = (accept && !pop) ? cnt_q + ONE_C : ((pop && !accept) ? cnt_q - ONE_C : cnt_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q <= '0;
            hold_q <= '0;
            lock_q <= 1'b0;
            cnt_q <= '0;
            wr_q <= '0;
            rd_q <= '0;
            err_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
            hold_q <= sel;
            lock_q <= lock_d;
            cnt_q <= cnt_d;
            wr_q <= accept ? wr_q + PW'(1) : wr_q;
            rd_q <= pop ? rd_q + PW'(1) : rd_q;
            err_q <= err_q || (mem_res_valid && empty);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) ids_q[wr_q] <= sel;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table plus corner-case sequences for the 2-channel, depth-4 arbiter;
// granted channel IDs go into a scoreboard queue and are matched against routed responses.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [1:0] ch_req_valid, ch_req_ready, ch_res_valid;
    logic [63:0] ch_req_addr, ch_req_data;
    logic [3:0] ch_req_fcn;
    logic [5:0] ch_req_typ;
    logic [31:0] ch_res_data, mem_req_addr, mem_req_data, mem_res_data;
    logic mem_req_valid, mem_req_ready, mem_res_valid, err_unexpected_res;
    logic [1:0] mem_req_fcn;
    logic [2:0] mem_req_typ, outstanding;
    logic [31:0] a0 = 32'h100, a1 = 32'h200;
    int checks = 0, errors = 0;
    int q[$];

    typedef struct {
        logic [1:0] v;
        logic rdy;
        logic rv;
        logic [31:0] rd;
        logic mv;
        logic [1:0] er;
        logic [2:0] eo;
    } vec_t;
    vec_t tbl [12];

    always #5 clk = ~clk;

    assign ch_req_addr = {a1, a0};
    assign ch_req_data = {32'hD1D1_0001, 32'hD0D0_0000};
    assign ch_req_fcn = {2'd2, 2'd1};
    assign ch_req_typ = {3'd5, 3'd2};

    mem_port_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .ch_req_valid(ch_req_valid), .ch_req_addr(ch_req_addr), .ch_req_data(ch_req_data),
        .ch_req_fcn(ch_req_fcn), .ch_req_typ(ch_req_typ), .ch_req_ready(ch_req_ready),
        .ch_res_valid(ch_res_valid), .ch_res_data(ch_res_data),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_req_fcn(mem_req_fcn), .mem_req_typ(mem_req_typ), .mem_req_ready(mem_req_ready),
        .mem_res_valid(mem_res_valid), .mem_res_data(mem_res_data),
        .outstanding(outstanding), .err_unexpected_res(err_unexpected_res)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // hold >= 0 names the channel whose fields must be on mem_req_* even without a grant
    task automatic step(input logic [1:0] v, input logic rdy, input logic rv, input logic [31:0] rd,
                        input logic mv, input logic [1:0] er, input logic [2:0] eo, input int hold);
        int ch;
        logic [1:0] eres;
        ch_req_valid = v;
        mem_req_ready = rdy;
        mem_res_valid = rv;
        mem_res_data = rd;
        #2;
        chk("mem_req_valid", 32'(mem_req_valid), 32'(mv));
        chk("ch_req_ready", 32'(ch_req_ready), 32'(er));
        chk("outstanding", 32'(outstanding), 32'(eo));
        ch = er[1] ? 1 : (er[0] ? 0 : hold);
        if (ch >= 0) begin
            chk("mem_req_addr", mem_req_addr, ch == 1 ? a1 : a0);
            chk("mem_req_fcn", 32'(mem_req_fcn), ch == 1 ? 32'd2 : 32'd1);
            chk("mem_req_typ", 32'(mem_req_typ), ch == 1 ? 32'd5 : 32'd2);
        end
        eres = '0;
        if (rv && q.size() > 0) eres = 2'b01 << q.pop_front();
        chk("ch_res_valid", 32'(ch_res_valid), 32'(eres));
        if (eres != 0) chk("ch_res_data", ch_res_data, rd);
        if (er != 0) q.push_back(ch);
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ch_req_valid = '0;
        mem_req_ready = 1'b0;
        mem_res_valid = 1'b0;
        mem_res_data = '0;
        tick();
        tick();
        reset = 1'b0;
        q.delete();
    endtask

    initial begin
        tbl = '{
            '{2'b11, 1'b1, 1'b0, 32'h0,  1'b1, 2'b01, 3'd0},
            '{2'b11, 1'b1, 1'b0, 32'h0,  1'b1, 2'b10, 3'd1},
            '{2'b11, 1'b1, 1'b0, 32'h0,  1'b1, 2'b01, 3'd2},
            '{2'b11, 1'b1, 1'b0, 32'h0,  1'b1, 2'b10, 3'd3},
            '{2'b10, 1'b1, 1'b0, 32'h0,  1'b0, 2'b00, 3'd4},
            '{2'b10, 1'b1, 1'b1, 32'hAA, 1'b0, 2'b00, 3'd4},
            '{2'b10, 1'b1, 1'b0, 32'h0,  1'b1, 2'b10, 3'd3},
            '{2'b00, 1'b1, 1'b1, 32'hB1, 1'b0, 2'b00, 3'd4},
            '{2'b00, 1'b1, 1'b1, 32'hB2, 1'b0, 2'b00, 3'd3},
            '{2'b00, 1'b1, 1'b1, 32'hB3, 1'b0, 2'b00, 3'd2},
            '{2'b00, 1'b1, 1'b1, 32'hB4, 1'b0, 2'b00, 3'd1},
            '{2'b00, 1'b1, 1'b1, 32'hB5, 1'b0, 2'b00, 3'd0}
        };
        ch_req_valid = 2'b11;
        mem_req_ready = 1'b1;
        mem_res_valid = 1'b1;
        mem_res_data = '0;
        #2;
        chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_ch_req_ready", 32'(ch_req_ready), 32'd0);
        chk("rst_ch_res_valid", 32'(ch_res_valid), 32'd0);
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        tick();
        tick();
        chk("rst_err", 32'(err_unexpected_res), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++)
            step(tbl[i].v, tbl[i].rdy, tbl[i].rv, tbl[i].rd, tbl[i].mv, tbl[i].er, tbl[i].eo, -1);
        chk("tbl_err_sticky", 32'(err_unexpected_res), 32'd1);

        // stall with lock: ch0 held while ch1 appears, then a lock taken with rr pointing at ch1
        do_reset();
        step(2'b01, 1'b0, 1'b0, 32'h0,  1'b1, 2'b00, 3'd0, 0);
        step(2'b11, 1'b0, 1'b0, 32'h0,  1'b1, 2'b00, 3'd0, 0);
        step(2'b11, 1'b0, 1'b0, 32'h0,  1'b1, 2'b00, 3'd0, 0);
        step(2'b11, 1'b1, 1'b0, 32'h0,  1'b1, 2'b01, 3'd0, -1);
        step(2'b10, 1'b1, 1'b0, 32'h0,  1'b1, 2'b10, 3'd1, -1);
        step(2'b01, 1'b1, 1'b0, 32'h0,  1'b1, 2'b01, 3'd2, -1);
        step(2'b01, 1'b0, 1'b0, 32'h0,  1'b1, 2'b00, 3'd3, 0);
        step(2'b11, 1'b0, 1'b0, 32'h0,  1'b1, 2'b00, 3'd3, 0);
        step(2'b11, 1'b1, 1'b0, 32'h0,  1'b1, 2'b01, 3'd3, -1);
        step(2'b00, 1'b1, 1'b1, 32'hC0, 1'b0, 2'b00, 3'd4, -1);
        step(2'b00, 1'b1, 1'b1, 32'hC1, 1'b0, 2'b00, 3'd3, -1);
        step(2'b00, 1'b1, 1'b1, 32'hC2, 1'b0, 2'b00, 3'd2, -1);
        step(2'b00, 1'b1, 1'b1, 32'hC3, 1'b0, 2'b00, 3'd1, -1);
        step(2'b00, 1'b1, 1'b0, 32'h0,  1'b0, 2'b00, 3'd0, -1);
        chk("lock_no_err", 32'(err_unexpected_res), 32'd0);

        // in-order routing: ch1 then ch0
        do_reset();
        a0 = 32'h20;
        a1 = 32'h10;
        step(2'b10, 1'b1, 1'b0, 32'h0,  1'b1, 2'b10, 3'd0, -1);
        step(2'b01, 1'b1, 1'b0, 32'h0,  1'b1, 2'b01, 3'd1, -1);
        step(2'b00, 1'b1, 1'b1, 32'hAA, 1'b0, 2'b00, 3'd2, -1);
        step(2'b00, 1'b1, 1'b1, 32'hBB, 1'b0, 2'b00, 3'd1, -1);
        step(2'b00, 1'b1, 1'b0, 32'h0,  1'b0, 2'b00, 3'd0, -1);
        a0 = 32'h100;
        a1 = 32'h200;

        // unexpected response, then asynchronous clear
        do_reset();
        step(2'b00, 1'b0, 1'b1, 32'h55, 1'b0, 2'b00, 3'd0, -1);
        chk("err_set", 32'(err_unexpected_res), 32'd1);
        step(2'b00, 1'b0, 1'b0, 32'h0,  1'b0, 2'b00, 3'd0, -1);
        chk("err_held", 32'(err_unexpected_res), 32'd1);
        reset = 1'b1;
        #1;
        chk("err_async_clr", 32'(err_unexpected_res), 32'd0);
        tick();
        reset = 1'b0;

        // reset with 3 outstanding
        step(2'b11, 1'b1, 1'b0, 32'h0,  1'b1, 2'b01, 3'd0, -1);
        step(2'b11, 1'b1, 1'b0, 32'h0,  1'b1, 2'b10, 3'd1, -1);
        step(2'b11, 1'b1, 1'b0, 32'h0,  1'b1, 2'b01, 3'd2, -1);
        chk("pre_rst_outstanding", 32'(outstanding), 32'd3);
        ch_req_valid = 2'b11;
        mem_req_ready = 1'b1;
        mem_res_valid = 1'b1;
        reset = 1'b1;
        #1;
        chk("mid_rst_outstanding", 32'(outstanding), 32'd0);
        chk("mid_rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("mid_rst_ch_req_ready", 32'(ch_req_ready), 32'd0);
        chk("mid_rst_ch_res_valid", 32'(ch_res_valid), 32'd0);
        tick();
        reset = 1'b0;
        q.delete();
        step(2'b11, 1'b1, 1'b0, 32'h0,  1'b1, 2'b01, 3'd0, -1);
        step(2'b10, 1'b1, 1'b0, 32'h0,  1'b1, 2'b10, 3'd1, -1);
        step(2'b00, 1'b1, 1'b1, 32'hE0, 1'b0, 2'b00, 3'd2, -1);
        step(2'b00, 1'b1, 1'b1, 32'hE1, 1'b0, 2'b00, 3'd1, -1);
        chk("post_rst_no_err", 32'(err_unexpected_res), 32'd0);
        step(2'b00, 1'b1, 1'b1, 32'hE2, 1'b0, 2'b00, 3'd0, -1);
        chk("post_rst_unexpected", 32'(err_unexpected_res), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
